// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU and immediate selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WB      = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_LOAD_WB = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_TRAP    = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  function automatic logic [1:0] imm_sel_for(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    if (op == OP_STORE)  sel = IMM_S;
    if (op == OP_BRANCH) sel = IMM_B;
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_ctrl_decode.sv
// Combinational funct3/funct7 -> ALU operation decode; flags funct3 values outside the subset.
module alu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int FUNCT7_SUB_BIT = 5
) (
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_is_rtype,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal
);

  // Only the sub-select bit of funct7 matters in this subset.
  logic w_unused_funct7;
  assign w_unused_funct7 = ^i_funct7;

  always_comb begin
    o_alu_ctrl = ALU_AND;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_ADD:  o_alu_ctrl = (i_is_rtype && i_funct7[FUNCT7_SUB_BIT]) ? ALU_SUB : ALU_ADD;
      F3_AND:  o_alu_ctrl = ALU_AND;
      F3_OR:   o_alu_ctrl = ALU_OR;
      default: o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV64 sequencing FSM; R/I 4, ld 5, sd 4, beq 3 cycles plus one per memory wait state.
// mem_req holds until mem_ready; PERF_COUNTERS_EN adds cycle_count/instret outputs.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int FUNCT7_SUB_BIT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] imm_sel,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state_dbg
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic       w_is_rtype;
  logic [3:0] w_alu_ctrl;
  logic       w_alu_illegal;

  assign w_is_rtype = (opcode == OP_RTYPE);

  alu_ctrl_decode #(
    .FUNCT7_SUB_BIT(FUNCT7_SUB_BIT)
  ) u_alu_dec (
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .i_is_rtype(w_is_rtype),
    .o_alu_ctrl(w_alu_ctrl),
    .o_illegal (w_alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Outputs are forced low during reset so an in-flight request drops at once.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_AND;
    imm_sel    = IMM_I;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          imm_sel = imm_sel_for(opcode);
          case (opcode)
            OP_RTYPE, OP_ITYPE: w_next = S_EXEC;
            OP_LOAD, OP_STORE:  w_next = (funct3 == F3_DW)  ? S_ADDR   : S_TRAP;
            OP_BRANCH:          w_next = (funct3 == F3_BEQ) ? S_BRANCH : S_TRAP;
            default:            w_next = S_TRAP;
          endcase
        end
        S_EXEC: begin
          alu_src_b = (opcode == OP_ITYPE);
          alu_ctrl  = w_alu_ctrl;
          w_next    = w_alu_illegal ? S_TRAP : S_WB;
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_ADDR: begin
          alu_src_b = 1'b1;
          alu_ctrl  = ALU_ADD;
          imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
          w_next    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = S_LOAD_WB;
        end
        S_LOAD_WB: begin
          reg_write  = 1'b1;
          wb_sel     = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        end
        S_BRANCH: begin
          alu_ctrl   = ALU_SUB;
          imm_sel    = IMM_B;
          pc_src     = 1'b1;
          pc_write   = alu_zero;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_TRAP:  halted = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end

  assign state_dbg = reset ? 4'd0 : 4'(r_state);

`ifdef PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [CNT_WIDTH-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_instret     <= '0;
    end else begin
      if (!halted)    r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      if (instr_done) r_instret     <= r_instret + CNT_WIDTH'(1);
    end
  end

  assign cycle_count = reset ? '0 : r_cycle_count;
  assign instret     = reset ? '0 : r_instret;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Trace-driven bench: a per-instruction model expands each instruction into its expected cycle trace.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] imm_sel;
    logic       instr_done;
    logic       halted;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    out_t        o;
    logic [31:0] cyc;
    logic [31:0] ret;
  } rec_t;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, wb_sel, alu_src_b, instr_done, halted;
  logic [3:0] alu_ctrl;
  logic [1:0] imm_sel;
  logic [3:0] state_dbg;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count;
  logic [31:0] instret;
`endif

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_b (alu_src_b),
    .alu_ctrl  (alu_ctrl),
    .imm_sel   (imm_sel),
    .instr_done(instr_done),
    .halted    (halted),
    .state_dbg (state_dbg)
`ifdef PERF_COUNTERS_EN
    ,
    .cycle_count(cycle_count),
    .instret    (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  rec_t        q[$];
  rec_t        cur;
  logic [31:0] run_cyc = 0;
  logic [31:0] run_ret = 0;
  logic [6:0]  g_op = 0;
  logic [2:0]  g_f3 = 0;
  logic [6:0]  g_f7 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic out_t blank(input int st);
    out_t o;
    o = '0;
    o.state = 4'(st);
    return o;
  endfunction

  task automatic push(input out_t o, input logic rdy, input logic zero);
    rec_t r;
    r.rst = 1'b0; r.rdy = rdy; r.zero = zero;
    r.op = g_op; r.f3 = g_f3; r.f7 = g_f7;
    r.o = o; r.cyc = run_cyc; r.ret = run_ret;
    q.push_back(r);
    if (!o.halted)    run_cyc = run_cyc + 1;
    if (o.instr_done) run_ret = run_ret + 1;
  endtask

  task automatic push_reset();
    rec_t r;
    r.rst = 1'b1; r.rdy = rb(); r.zero = rb();
    r.op = g_op; r.f3 = g_f3; r.f7 = g_f7;
    r.o = blank(0); r.cyc = 0; r.ret = 0;
    q.push_back(r);
    run_cyc = 0;
    run_ret = 0;
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace.
  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm, input logic zero, input int trap_len);
    out_t o;
    int   kind;  // 0 alu, 1 load, 2 store, 3 beq, 4 trap
    g_op = op; g_f3 = f3; g_f7 = f7;
    for (int i = 0; i < wf; i++) begin
      o = blank(0); o.mem_req = 1; push(o, 1'b0, rb());
    end
    o = blank(0); o.mem_req = 1; o.ir_write = 1; o.pc_write = 1; push(o, 1'b1, rb());
    if (op == 7'h33 || op == 7'h13)                      kind = 0;
    else if ((op == 7'h03 || op == 7'h23) && f3 == 3'd3) kind = (op == 7'h03) ? 1 : 2;
    else if (op == 7'h63 && f3 == 3'd0)                  kind = 3;
    else                                                 kind = 4;
    o = blank(1);
    o.imm_sel = (op == 7'h23) ? 2'd1 : (op == 7'h63) ? 2'd2 : 2'd0;
    push(o, rb(), rb());
    case (kind)
      0: begin
        o = blank(2);
        o.alu_src_b = (op == 7'h13);
        case (f3)
          3'd0:    o.alu_ctrl = (op == 7'h33 && f7[5]) ? 4'd6 : 4'd2;
          3'd7:    o.alu_ctrl = 4'd0;
          3'd6:    o.alu_ctrl = 4'd1;
          default: kind = 4;
        endcase
        push(o, rb(), rb());
        if (kind == 0) begin
          o = blank(3); o.reg_write = 1; o.instr_done = 1; push(o, rb(), rb());
        end
      end
      1, 2: begin
        o = blank(4); o.alu_src_b = 1; o.alu_ctrl = 4'd2;
        o.imm_sel = (kind == 2) ? 2'd1 : 2'd0;
        push(o, rb(), rb());
        o = blank((kind == 1) ? 5 : 7);
        o.mem_req = 1; o.iord = 1; o.mem_we = (kind == 2);
        for (int i = 0; i < wm; i++) push(o, 1'b0, rb());
        o.instr_done = (kind == 2);
        push(o, 1'b1, rb());
        if (kind == 1) begin
          o = blank(6); o.reg_write = 1; o.wb_sel = 1; o.instr_done = 1; push(o, rb(), rb());
        end
      end
      3: begin
        o = blank(8); o.alu_ctrl = 4'd6; o.imm_sel = 2'd2; o.pc_src = 1;
        o.pc_write = zero; o.instr_done = 1;
        push(o, rb(), zero);
      end
      default: ;
    endcase
    if (kind == 4) begin
      for (int i = 0; i < trap_len; i++) begin
        o = blank(9); o.halted = 1; push(o, rb(), rb());
      end
      push_reset();
    end
  endtask

  task automatic compare_cycle();
    out_t a;
    a = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, wb_sel,
         alu_src_b, alu_ctrl, imm_sel, instr_done, halted, state_dbg};
    check(cur.rst ? "reset_outputs" : "outputs", 64'(a), 64'(cur.o));
`ifdef PERF_COUNTERS_EN
    check("cycle_count", 64'(cycle_count), 64'(cur.cyc));
    check("instret", 64'(instret), 64'(cur.ret));
`endif
  endtask

  initial begin
    int n0;
    reset = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;

    push_reset(); push_reset();

    // addi x1,x0,10, zero-wait
    n0 = q.size();
    gen_instr(7'h13, 3'd0, 7'd0, 0, 0, 1'b0, 0);
    check("addi_len", 64'(q.size() - n0), 64'd4);
    check("addi_ir_write_c1", 64'(q[n0].o.ir_write), 64'd1);
    check("addi_reg_write_c4", 64'(q[n0+3].o.reg_write), 64'd1);

    // ld with two wait states on fetch and on the data read
    n0 = q.size();
    gen_instr(7'h03, 3'd3, 7'd0, 2, 2, 1'b0, 0);
    check("ld_len", 64'(q.size() - n0), 64'd9);
    check("ld_wb_c9", 64'({q[n0+8].o.reg_write, q[n0+8].o.wb_sel}), 64'b11);

    n0 = q.size();
    gen_instr(7'h63, 3'd0, 7'd0, 0, 0, 1'b1, 0);
    check("beq_taken_len", 64'(q.size() - n0), 64'd3);
    check("beq_taken_pcw", 64'({q[n0+2].o.pc_write, q[n0+2].o.pc_src}), 64'b11);
    n0 = q.size();
    gen_instr(7'h63, 3'd0, 7'd0, 0, 0, 1'b0, 0);
    check("beq_fall_len", 64'(q.size() - n0), 64'd3);
    check("beq_fall_pcw", 64'(q[n0+2].o.pc_write), 64'd0);

    // illegal opcode: halted for 20 cycles, then reset
    gen_instr(7'h7F, 3'd0, 7'd0, 0, 0, 1'b0, 20);

    // sd interrupted by reset while waiting on the write
    gen_instr(7'h23, 3'd3, 7'd0, 0, 5, 1'b0, 0);
    void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
    push_reset();
    gen_instr(7'h33, 3'd0, 7'h20, 1, 0, 1'b0, 0);

    // add, sd, beq from reset with zero wait states
    push_reset();
    gen_instr(7'h33, 3'd0, 7'd0, 0, 0, 1'b0, 0);
    gen_instr(7'h23, 3'd3, 7'd0, 0, 0, 1'b0, 0);
    gen_instr(7'h63, 3'd0, 7'd0, 0, 0, 1'b1, 0);
    check("perf_cycles", 64'(run_cyc), 64'd11);
    check("perf_instret", 64'(run_ret), 64'd3);
    gen_instr(7'h13, 3'd7, 7'd0, 0, 0, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      int         sel;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      sel = $urandom_range(0, 9);
      f3  = 3'($urandom);
      f7  = 7'($urandom);
      case (sel)
        0, 1, 2, 3: begin
          op = (sel < 2) ? 7'h33 : 7'h13;
          if ($urandom_range(0, 7) != 0)
            case ($urandom_range(0, 2))
              0:       f3 = 3'd0;
              1:       f3 = 3'd7;
              default: f3 = 3'd6;
            endcase
        end
        4, 5: begin
          op = (sel == 4) ? 7'h03 : 7'h23;
          if ($urandom_range(0, 7) != 0) f3 = 3'd3;
        end
        6, 7: begin
          op = 7'h63;
          if ($urandom_range(0, 7) != 0) f3 = 3'd0;
        end
        8:       op = 7'($urandom);
        default: op = 7'h33;
      endcase
      gen_instr(op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                $urandom_range(2, 6));
      if ($urandom_range(0, 40) == 0) push_reset();
    end

    // Replay the trace: drive just after the edge, compare on the falling edge.
    @(posedge clk); #1;
    while (q.size() > 0) begin
      cur       = q.pop_front();
      reset     = cur.rst;
      mem_ready = cur.rdy;
      alu_zero  = cur.zero;
      opcode    = cur.op;
      funct3    = cur.f3;
      funct7    = cur.f7;
      @(negedge clk);
      compare_cycle();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle variant of the sequential RV64 core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with a req/ready handshake. It drives every datapath enable and mux select: PC, IR, register file, ALU and memory. Supported subset: add, sub, and, or, addi, ld, sd, beq; any other opcode traps.

Parameters:
CNT_WIDTH, 32, width of optional perf counters
FUNCT7_SUB_BIT, 5, bit of funct7 selecting sub over add

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
alu_zero  in  1  ALU result == 0
mem_ready  in  1  memory completes current request
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write (sd)
iord  out  1  0 = address from PC, 1 = address from ALU result
ir_write  out  1  latch IR and pc_old
pc_write  out  1  load PC
pc_src  out  1  0 = PC+4, 1 = pc_old+imm
reg_write  out  1  register file write enable
wb_sel  out  1  0 = ALU result, 1 = memory data
alu_src_b  out  1  0 = rs2, 1 = immediate
alu_ctrl  out  4  0000 and, 0001 or, 0010 add, 0110 sub
imm_sel  out  2  0 = I-type, 1 = S-type, 2 = B-type
instr_done  out  1  one-cycle pulse at retire
halted  out  1  sticky; illegal opcode seen
state_dbg  out  4  current state encoding

Behaviour:
- Reset: synchronous, active-high. At the edge with reset=1, state goes to S_FETCH. All outputs are 0 while reset is high; state_dbg=0. Reset mid-transaction drops mem_req immediately and does not wait for mem_ready.
- All outputs are Moore, decoded from state only, except: pc_write in S_BRANCH is alu_zero; reg_write/pc_write/ir_write/instr_done are gated by their handshake conditions as listed.
- S_FETCH: mem_req=1, iord=0, mem_we=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to S_DECODE. Otherwise stay.
- S_DECODE: imm_sel set from opcode.
  - 0110011 or 0010011 -> S_EXEC
  - 0000011 or 0100011 with funct3=011 -> S_ADDR
  - 1100011 with funct3=000 -> S_BRANCH
  - anything else -> S_TRAP
- S_EXEC: alu_src_b = (opcode==0010011). alu_ctrl decoded from funct3/funct7:
  - 000 -> add; sub when R-type and funct7[5]=1
  - 111 -> and
  - 110 -> or
  - any other funct3 -> S_TRAP instead of S_WB
  - Next state S_WB.
- S_WB: reg_write=1, wb_sel=0, instr_done=1 -> S_FETCH.
- S_ADDR: alu_src_b=1, alu_ctrl=add, imm_sel I (load) or S (store). Load -> S_MEM_RD; store -> S_MEM_WR.
- S_MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ready -> S_LOAD_WB.
- S_LOAD_WB: reg_write=1, wb_sel=1, instr_done=1 -> S_FETCH.
- S_MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready: instr_done=1, then S_FETCH.
- S_BRANCH: alu_src_b=0, alu_ctrl=sub, imm_sel=B, pc_src=1, pc_write=alu_zero, instr_done=1 -> S_FETCH.
- S_TRAP: halted=1, all enables 0, no exit except reset.
- Handshake rules:
  - mem_req, iord and mem_we stay stable until the cycle mem_ready is seen.
  - mem_ready is ignored when mem_req=0.
  - mem_ready may be high in the first request cycle (zero-wait).
- Latency with zero wait states: R/I = 4 cycles, ld = 5, sd = 4, beq = 3. Each memory wait state adds 1 cycle.
- rd=x0 writes are still issued; the register file discards them.

Optional Feature:
PERF_COUNTERS_EN
- Defined: adds outputs cycle_count[CNT_WIDTH-1:0] and instret[CNT_WIDTH-1:0].
  - Both clear on reset.
  - cycle_count increments every non-reset cycle while !halted.
  - instret increments on instr_done.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: the ports and logic are absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding (S_FETCH=0 … S_TRAP=9)
  - opcode constants
  - alu_ctrl codes
  - imm_sel codes
- One sub-module, alu_ctrl_decode: combinational funct3/funct7/is_rtype -> alu_ctrl plus an illegal flag.

Test Plan:
- addi x1,x0,10 with zero-wait memory -> ir_write in cycle 1, reg_write in cycle 4, instr_done once, back to S_FETCH.
- ld with mem_ready delayed 2 cycles in both fetch and MEM_RD -> mem_req held stable with iord=1 during the read, reg_write with wb_sel=1 at cycle 9.
- beq with alu_zero=1, then with alu_zero=0 -> pc_write=1/pc_src=1 in the first case, pc_write=0 in the second; both take 3 cycles.
- opcode 0x7F -> S_TRAP; halted=1 sticky; mem_req stays 0 for 20 cycles; reset clears it.
- reset asserted in S_MEM_WR before mem_ready -> mem_req=0 and state_dbg=0 on the next edge; the next fetch starts cleanly.
- PERF_COUNTERS_EN, 3 instructions (add/sd/beq), zero-wait -> instret=3, cycle_count=11.
